uart_tx_frame_ctrl: RTL and testbench

Transmit-side frame sequencer for the UART datapath. Accepts one character per valid/ready handshake, latches the per-frame UART configuration, and drives the serial line through the start, data, parity and stop phases. Bit timing comes from a baud-divisor/oversampling tick chain. It sits between the character source (driver BFM or FIFO) and the `tx` pin.

---
 rtl/uart_tx_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame sequencer; parity stage compiled in by UART_TX_PARITY_EN
module uart_tx_frame_ctrl #(
    parameter int CHAR_LENGTH = 8,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIV_WIDTH-1:0]   cfg_baud_div,
    input  logic [3:0]             cfg_oversampling,
    input  logic [3:0]             cfg_uart_type,
    input  logic [1:0]             cfg_stop_bit,
    input  logic                   cfg_msb_first,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_type,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [CHAR_LENGTH-1:0] tx_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]           samp_cnt_q, samp_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;

    // Per-frame configuration captured on accept
    logic [DIV_WIDTH-1:0] div_q;
    logic [3:0]           os_q;
    logic [3:0]           n_q;
    logic [1:0]           stop_q;
    logic                 msb_q;
    logic [7:0]           data_q;
    logic                 cfg_err_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q;
    logic                 par_type_q;
    logic                 parity_bit;
`else
    logic                 unused_parity;
`endif

    logic                 accept;
    logic                 cfg_legal;
    logic [7:0]           char_mask;
    logic                 tick;
    logic [4:0]           stop_ticks;
    logic [4:0]           phase_len;
    logic                 phase_end;
    logic                 last_bit;
    logic [2:0]           bit_sel;

    assign accept    = (state_q == S_IDLE) && tx_valid;
    assign cfg_legal = (cfg_uart_type >= 4'd5) && (cfg_uart_type <= 4'd8)
                     && ((cfg_oversampling == 4'd2) || (cfg_oversampling == 4'd4)
                      || (cfg_oversampling == 4'd6) || (cfg_oversampling == 4'd8))
                     && (cfg_baud_div != '0);
    // Unused high data bits are zeroed so parity can reduce over the whole byte
    assign char_mask = 8'((9'd1 << cfg_uart_type) - 9'd1);

    assign tick      = (div_cnt_q == div_q - DIV_WIDTH'(1));
    assign phase_len = (state_q == S_STOP) ? stop_ticks : {1'b0, os_q};
    assign phase_end = tick && (samp_cnt_q == phase_len - 5'd1);
    assign last_bit  = (bit_cnt_q == n_q - 4'd1);
    assign bit_sel   = msb_q ? 3'(n_q - 4'd1 - bit_cnt_q) : bit_cnt_q[2:0];

`ifdef UART_TX_PARITY_EN
    assign parity_bit = (^data_q) ^ par_type_q;
`else
    assign unused_parity = cfg_parity_en ^ cfg_parity_type;
`endif

    // Stop phase length in oversample ticks: 1, 1.5 or 2 bits
    always_comb begin
        case (stop_q)
            2'd0:    stop_ticks = {1'b0, os_q} + {2'b00, os_q[3:1]};
            2'd2:    stop_ticks = {os_q, 1'b0};
            default: stop_ticks = {1'b0, os_q};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each non-idle phase ends on its last oversample tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && cfg_legal) state_d = S_START;
            S_START:  if (phase_end) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (phase_end && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (phase_end) state_d = S_STOP;
`else
            S_DATA:   if (phase_end && last_bit) state_d = S_STOP;
`endif
            S_STOP:   if (phase_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state and tick position
    always_comb begin
        tx         = 1'b1;
        tx_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            S_START:  tx = 1'b0;
            S_DATA:   tx = data_q[bit_sel];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = parity_bit;
`endif
            S_STOP:   frame_done = phase_end;
            default:  busy = 1'b0;
        endcase
    end

    // Tick chain and bit counter; everything sits at zero while idle
    always_comb begin
        div_cnt_d  = div_cnt_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (state_q == S_IDLE) begin
            div_cnt_d  = '0;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
            if (tick) begin
                samp_cnt_d = phase_end ? 5'd0 : samp_cnt_q + 5'd1;
            end
            if ((state_q == S_DATA) && phase_end) begin
                bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Capture character and configuration on accept; flag dropped characters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            os_q       <= '0;
            n_q        <= '0;
            stop_q     <= '0;
            msb_q      <= 1'b0;
            data_q     <= '0;
            cfg_err_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
`endif
        end else begin
            cfg_err_q <= accept && !cfg_legal;
            if (accept) begin
                div_q      <= cfg_baud_div;
                os_q       <= cfg_oversampling;
                n_q        <= cfg_uart_type;
                stop_q     <= cfg_stop_bit;
                msb_q      <= cfg_msb_first;
                data_q     <= 8'(tx_data) & char_mask;
`ifdef UART_TX_PARITY_EN
                par_en_q   <= cfg_parity_en;
                par_type_q <= cfg_parity_type;
`endif
            end
        end
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - scoreboard bench for uart_tx_frame_ctrl
module tb_uart_tx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_baud_div = '0;
    logic [3:0]  cfg_oversampling = '0;
    logic [3:0]  cfg_uart_type = '0;
    logic [1:0]  cfg_stop_bit = '0;
    logic        cfg_msb_first = 1'b0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_type = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data = '0;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;

    uart_tx_frame_ctrl #(.CHAR_LENGTH(8), .DIV_WIDTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_baud_div     (cfg_baud_div),
        .cfg_oversampling (cfg_oversampling),
        .cfg_uart_type    (cfg_uart_type),
        .cfg_stop_bit     (cfg_stop_bit),
        .cfg_msb_first    (cfg_msb_first),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_parity_type  (cfg_parity_type),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .tx               (tx),
        .busy             (busy),
        .frame_done       (frame_done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit        is_err;
        int        acc;
        int        nlv;
        bit [10:0] lv;
        int        bit_clks;
        int        stop_clks;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: the frame as a list of bit levels plus timing in clocks
    function automatic exp_t model(input int data, input int n, input int os, input int d,
                                   input int stop, input bit msb, input bit pen,
                                   input bit ptype, input int acc);
        exp_t e;
        int   st;
        e.acc = acc;
        e.is_err = !(n >= 5 && n <= 8 && (os == 2 || os == 4 || os == 6 || os == 8) && d != 0);
        e.lv = '0;
        e.nlv = 1 + n;
        if (!e.is_err) begin
            for (int k = 0; k < n; k++)
                e.lv[1 + k] = msb ? (((data >> (n - 1 - k)) & 1) != 0) : (((data >> k) & 1) != 0);
`ifdef UART_TX_PARITY_EN
            if (pen) begin
                e.lv[1 + n] = ((($countones(data & ((1 << n) - 1)) % 2) != 0) ^ ptype);
                e.nlv = n + 2;
            end
`else
            if (pen && ptype) e.nlv = 1 + n;
`endif
        end
        st = (stop == 0) ? (os * 3) / 2 : (stop == 2) ? 2 * os : os;
        e.bit_clks = d * os;
        e.stop_clks = d * st;
        return e;
    endfunction

    // Monitor state
    bit rec = 0;
    int start_cyc = 0;
    bit trace[$];
    int last_done_cyc = -100;
    int idle_viol = 0;
    int stray = 0;

    task automatic check_frame();
        exp_t e;
        int   len;
        int   bad;
        bit   ex;
        chk("frame_unexpected", exp_q.size() == 0, 0);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("frame_was_expected", e.is_err, 0);
        if (e.is_err) return;
        chk("start_latency", start_cyc - e.acc, 0);
        len = e.nlv * e.bit_clks + e.stop_clks;
        chk("frame_len_clks", trace.size(), len);
        bad = -1;
        for (int i = 0; i < trace.size() && i < len; i++) begin
            ex = (i < e.nlv * e.bit_clks) ? e.lv[i / e.bit_clks] : 1'b1;
            if (trace[i] != ex && bad < 0) bad = i;
        end
        chk("tx_wave_first_bad_clk", bad, -1);
    endtask

    task automatic check_err();
        exp_t e;
        chk("cfg_err_unexpected", exp_q.size() == 0, 0);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("cfg_err_was_expected", e.is_err, 1);
        if (e.is_err) chk("cfg_err_latency", cyc - e.acc, 0);
    endtask

    // Monitor: records tx per clock during a frame and checks against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            rec = 0;
            trace.delete();
        end else begin
            if (busy && !rec) begin
                rec = 1;
                start_cyc = cyc;
                trace.delete();
            end
            if (busy) trace.push_back(tx);
            else begin
                if (tx !== 1'b1) idle_viol++;
                if (rec) begin
                    stray++;
                    rec = 0;
                end
            end
            if (frame_done) begin
                chk("done_inside_frame", busy, 1);
                last_done_cyc = cyc;
                check_frame();
                rec = 0;
            end
            if (cfg_err) check_err();
        end
    end

    task automatic send(input int data, input int n, input int os, input int d, input int stop,
                        input bit msb, input bit pen, input bit ptype, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        tx_data = data[7:0];
        cfg_uart_type = n[3:0];
        cfg_oversampling = os[3:0];
        cfg_baud_div = d[15:0];
        cfg_stop_bit = stop[1:0];
        cfg_msb_first = msb;
        cfg_parity_en = pen;
        cfg_parity_type = ptype;
        tx_valid = 1'b1;
        while (!tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait_bounded", w >= 5000, 0);
        @(posedge clk);
        #1;
        acc = cyc;
        tx_valid = 1'b0;
        exp_q.push_back(model(data & 255, n, os, d, stop, msb, pen, ptype, acc));
    endtask

    // Idle with scrambled configuration inputs, which must not disturb a running frame
    task automatic gap(input int n);
        @(negedge clk);
        tx_valid = 1'b0;
        cfg_baud_div = 16'($urandom_range(0, 7));
        cfg_oversampling = 4'($urandom);
        cfg_uart_type = 4'($urandom);
        cfg_stop_bit = 2'($urandom);
        cfg_msb_first = 1'($urandom);
        cfg_parity_en = 1'($urandom);
        cfg_parity_type = 1'($urandom);
        tx_data = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int w;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        gap(2);

        // Directed cases
        send(8'h55, 8, 2, 4, 1, 0, 0, 0, acc);
        gap(3);
        send(8'h41, 7, 4, 2, 2, 1, 1, 1, acc);
        gap(2);
        send(8'h1F, 5, 4, 1, 0, 0, 0, 0, acc);
        gap(2);
        send(8'hA5, 0, 4, 2, 1, 0, 0, 0, acc);
        gap(3);
        send(8'h3C, 8, 2, 0, 1, 0, 0, 0, acc);
        gap(3);
        send(8'h99, 8, 3, 2, 1, 0, 0, 0, acc);
        gap(3);

        // Reset during the third data bit (bit 2 of 0xFB is 0)
        send(8'hFB, 8, 2, 2, 1, 0, 0, 0, acc);
        repeat (13) @(posedge clk);
        #2;
        chk("pre_reset_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("reset_async_tx", tx, 1);
        chk("reset_async_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_tx_ready", tx_ready, 1);
        chk("post_reset_busy", busy, 0);
        send(8'hC3, 6, 2, 1, 1, 1, 1, 0, acc);

        // Back-to-back: second character waits for the idle clock after frame_done
        send(8'h81, 8, 2, 2, 2, 0, 1, 0, acc);
        send(8'h7E, 5, 6, 1, 0, 1, 1, 1, acc2);
        chk("b2b_accept_clk", acc2, last_done_cyc + 2);
        gap(2);

        // Randomized frames with occasional illegal configurations
        for (int it = 0; it < 40; it++) begin
            int n, os, d, st, data;
            bit msb, pen, pt;
            n = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9 + $urandom_range(0, 6))
                                             : $urandom_range(5, 8);
            os = ($urandom_range(0, 11) == 0) ? 2 * $urandom_range(0, 4) + 1 : 2 * $urandom_range(1, 4);
            d = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 3);
            st = $urandom_range(0, 3);
            data = $urandom_range(0, 255);
            msb = 1'($urandom);
            pen = 1'($urandom);
            pt = 1'($urandom);
            send(data, n, os, d, st, msb, pen, pt, acc);
            if ($urandom_range(0, 2) != 0) gap($urandom_range(1, 4));
        end

        gap(2);
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("idle_tx_high_violations", idle_viol, 0);
        chk("busy_end_without_done", stray, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
